icache_direct: RTL

- Direct-mapped, read-only instruction cache between the IF stage and the instruction memory port.
- Serves IF fetches from on-chip lines on a hit.
- On a miss, issues one 256-bit block read to IM, installs the line, then serves the fetch.
- Replaces the current pass-through wiring (Instr_address_2IM = Instr_address_2IC, iBlkRead = 0).

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_line_store.sv | 53 +++++
 rtl/icache_direct.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants, state type and geometry helpers for the
// direct-mapped instruction cache (icache_direct, icache_line_store).
package icache_pkg;

    localparam int LINE_BYTES       = 32;
    localparam int OFFSET_BITS      = 3;
    localparam int BYTE_OFFSET_BITS = 2;
    localparam int LINE_OFF_BITS    = OFFSET_BITS + BYTE_OFFSET_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    function automatic int index_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int num_lines);
        return 32 - LINE_OFF_BITS - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the cache: combinational read at rd_index,
// synchronous line write, global valid clear.
// Ports: clk, rst_n (async, active-low), rd_index -> rd_valid/rd_tag/rd_data,
//        wr_en/wr_index/wr_tag/wr_data (line install), clear (all valids).
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int LINE_BITS = 256,
    localparam int IW = index_bits(NUM_LINES),
    localparam int TW = tag_bits(NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IW-1:0]        rd_index,
    output logic                 rd_valid,
    output logic [TW-1:0]        rd_tag,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_index,
    input  logic [TW-1:0]        wr_tag,
    input  logic [LINE_BITS-1:0] wr_data,
    input  logic                 clear
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TW-1:0]        tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    // Clear wins over a write; the controller never asks for both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache between IF and IM: 0-cycle hits,
// one 256-bit block read per miss, global invalidate.
// Ports: CLK, RESET (async, active-low); IF side Instr_address_2IC,
//        Fetch_req_fIF, Instr1/2_fIC, Instr1/2_valid_fIC, Stall_fIC;
//        IM side Instr_address_2IM, iBlkRead, block_read_fIM(_valid);
//        SYS Invalidate.
// Optional: define ICACHE_STATS_EN to add Hit_count / Miss_count outputs.
module icache_direct
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
`ifdef ICACHE_STATS_EN
    output logic [31:0]               Hit_count,
    output logic [31:0]               Miss_count,
`endif
    input  logic [31:0]               Instr_address_2IC,
    input  logic                      Fetch_req_fIF,
    input  logic                      Invalidate,
    output logic [31:0]               Instr1_fIC,
    output logic [31:0]               Instr2_fIC,
    output logic                      Instr1_valid_fIC,
    output logic                      Instr2_valid_fIC,
    output logic                      Stall_fIC,
    output logic [31:0]               Instr_address_2IM,
    output logic                      iBlkRead,
    input  logic [LINE_WORDS*32-1:0]  block_read_fIM,
    input  logic                      block_read_fIM_valid
);

    localparam int IW = index_bits(NUM_LINES);
    localparam int TW = tag_bits(NUM_LINES);
    localparam int LB = LINE_WORDS * 32;

    state_t state, next_state;
    logic [31:0] fill_addr, fill_addr_d;

    logic [OFFSET_BITS-1:0] offset, offset_n;
    logic [IW-1:0]          index;
    logic [TW-1:0]          tag;
    logic                   rd_valid;
    logic [TW-1:0]          rd_tag;
    logic [LB-1:0]          rd_data;
    logic                   wr_en, clear, hit;
    logic                   unused_pc_bits;

    assign offset   = Instr_address_2IC[LINE_OFF_BITS-1:BYTE_OFFSET_BITS];
    assign index    = Instr_address_2IC[LINE_OFF_BITS+IW-1:LINE_OFF_BITS];
    assign tag      = Instr_address_2IC[31:LINE_OFF_BITS+IW];
    assign offset_n = offset + 1'b1;
    assign unused_pc_bits = ^Instr_address_2IC[BYTE_OFFSET_BITS-1:0];

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LB)
    ) u_store (
        .clk      (CLK),
        .rst_n    (RESET),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (fill_addr[LINE_OFF_BITS+IW-1:LINE_OFF_BITS]),
        .wr_tag   (fill_addr[31:LINE_OFF_BITS+IW]),
        .wr_data  (block_read_fIM),
        .clear    (clear)
    );

    // Lookups only count in IDLE: no hit-under-miss.
    assign hit = (state == IDLE) && Fetch_req_fIF
              && rd_valid && (rd_tag == tag);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            fill_addr <= '0;
        end else begin
            state     <= next_state;
            fill_addr <= fill_addr_d;
        end
    end

    always_comb begin
        next_state  = state;
        fill_addr_d = fill_addr;
        wr_en       = 1'b0;
        clear       = 1'b0;
        Stall_fIC   = 1'b0;
        iBlkRead    = 1'b0;
        unique case (state)
            IDLE: begin
                clear = Invalidate;
                if (Fetch_req_fIF && !hit) begin
                    Stall_fIC   = 1'b1;
                    next_state  = FILL;
                    fill_addr_d = {Instr_address_2IC[31:LINE_OFF_BITS],
                                   {LINE_OFF_BITS{1'b0}}};
                end
            end
            FILL: begin
                iBlkRead  = 1'b1;
                Stall_fIC = Fetch_req_fIF;
                // Invalidate aborts the fill even if data arrives now.
                if (Invalidate) begin
                    clear      = 1'b1;
                    next_state = IDLE;
                end else if (block_read_fIM_valid) begin
                    wr_en      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign Instr_address_2IM = fill_addr;
    assign Instr1_valid_fIC  = hit;
    assign Instr2_valid_fIC  = hit && (offset != {OFFSET_BITS{1'b1}});
    assign Instr1_fIC = hit ? rd_data[offset*32 +: 32] : '0;
    assign Instr2_fIC = Instr2_valid_fIC ? rd_data[offset_n*32 +: 32] : '0;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Hit_count  <= '0;
            Miss_count <= '0;
        end else begin
            if (hit)
                Hit_count <= Hit_count + 32'd1;
            if (state == IDLE && next_state == FILL)
                Miss_count <= Miss_count + 32'd1;
        end
    end
`endif

endmodule
